upsample2d_nn: RTL and testbench

Streaming 2x nearest-neighbour upsampler. It expands an IN_W x IN_H raster frame of DATA_W-bit pixels into a 2*IN_W x 2*IN_H frame. This is the expand-side counterpart of the 2x2 average-pool stage, used on the decoder path to restore spatial resolution. Each input pixel is emitted twice horizontally, and each input row is emitted twice vertically from a one-row line buffer.

---
 rtl/upsample_pkg.sv | 23 ++
 rtl/upsample_line_buf.sv | 43 ++++
 rtl/upsample2d_nn.sv | 196 +++++++++++++++++++
 tb/tb_upsample2d_nn.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// ----------------------------------------------------------------------------
// upsample_pkg
// Shared definitions for the 2x nearest-neighbour upsampler: the row-copy
// state enum, the default pixel width and a helper that sizes the column and
// row counters so that a dimension of 1 still gets a one-bit counter.
// ----------------------------------------------------------------------------
package upsample_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // ROW_A emits the first copy of an input row while consuming input;
    // ROW_B replays the same row from the line buffer.
    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } state_t;

    // Counter width for a dimension of n entries, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// ----------------------------------------------------------------------------
// upsample_line_buf
// One-row pixel store used to replay an input row for the second (vertical)
// copy. Contents are deliberately not reset; every location is written during
// the first copy of a row before it is read back in the second copy.
//
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   waddr  in   write column
//   wdata  in   pixel to store
//   raddr  in   read column
//   rdata  out  pixel at raddr (combinational read)
// ----------------------------------------------------------------------------
module upsample_line_buf
    import upsample_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Single write port: one pixel stored per accepted input during ROW_A.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read so ROW_B can load the output register in the same
    // cycle the column counter points at the pixel.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/upsample2d_nn.sv
// ----------------------------------------------------------------------------
// upsample2d_nn
// Streaming 2x nearest-neighbour upsampler. Each input pixel is emitted twice
// horizontally (phase 0 / phase 1) and each input row is emitted twice
// vertically: ROW_A passes the live input through while filling the line
// buffer, ROW_B replays the row from the line buffer.
//
// Ports:
//   clk        in   clock, all logic on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input pixel valid
//   in_ready   out  input accepted when in_valid && in_ready
//   in_data    in   input pixel, raster order
//   out_valid  out  output pixel valid (registered)
//   out_ready  in   downstream accept
//   out_data   out  output pixel (registered)
//   out_sol    out  first pixel of the output frame
//   out_eol    out  last pixel of an output row
//   out_eof    out  last pixel of the output frame
// ----------------------------------------------------------------------------
module upsample2d_nn
    import upsample_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IN_W   = 2,
    parameter int IN_H   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int COL_W = cnt_width(IN_W);
    localparam int ROW_W = cnt_width(IN_H);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_H - 1);

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              sol_q, sol_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;

    logic              le;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic              lb_we;
    logic [DATA_W-1:0] lb_rdata;

    // The output register may only be reloaded when it is empty or being
    // drained this cycle; otherwise everything downstream-visible holds.
    assign le       = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);

    upsample_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_W),
        .ADDR_W (COL_W)
    ) u_line_buf (
        .clk    (clk),
        .we     (lb_we),
        .waddr  (col_q),
        .wdata  (in_data),
        .raddr  (col_q),
        .rdata  (lb_rdata)
    );

    // State register: FSM state, counters, hold pixel and the output
    // register with its flags. The line buffer is intentionally not cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ROW_A;
            phase_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sol_q       <= sol_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
        end
    end

    // Next-state logic. ROW_A phase 0 waits for an input pixel, phase 1
    // repeats it from the hold register. ROW_B walks the line buffer twice
    // per column. Row advances only when the replay row finishes, which is
    // also where the frame wraps back to row 0 without a bubble.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sol_d       = sol_q;
        eol_d       = eol_q;
        eof_d       = eof_q;

        unique case (state_q)
            ROW_A: begin
                if (!phase_q) begin
                    if (accept) begin
                        out_data_d  = in_data;
                        hold_d      = in_data;
                        out_valid_d = 1'b1;
                        phase_d     = 1'b1;
                        sol_d       = (row_q == '0) && (col_q == '0);
                        eol_d       = 1'b0;
                        eof_d       = 1'b0;
                    end else if (le) begin
                        out_valid_d = 1'b0;
                        sol_d       = 1'b0;
                        eol_d       = 1'b0;
                        eof_d       = 1'b0;
                    end
                end else if (le) begin
                    out_data_d  = hold_q;
                    out_valid_d = 1'b1;
                    phase_d     = 1'b0;
                    sol_d       = 1'b0;
                    eol_d       = last_col;
                    eof_d       = 1'b0;
                    if (last_col) begin
                        col_d   = '0;
                        state_d = ROW_B;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            ROW_B: begin
                if (le) begin
                    out_data_d  = lb_rdata;
                    out_valid_d = 1'b1;
                    phase_d     = !phase_q;
                    sol_d       = 1'b0;
                    eol_d       = phase_q && last_col;
                    eof_d       = phase_q && last_col && last_row;
                    if (phase_q) begin
                        if (last_col) begin
                            col_d   = '0;
                            state_d = ROW_A;
                            row_d   = last_row ? '0 : row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    // Output logic: input is only offered in ROW_A phase 0 when the output
    // register can take the pixel, so accepts are never back to back.
    always_comb begin
        in_ready = (state_q == ROW_A) && !phase_q && le;
        lb_we    = in_valid && in_ready;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sol   = sol_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;

endmodule

// File: tb/tb_upsample2d_nn.sv
// ----------------------------------------------------------------------------
// tb_upsample2d_nn
// Self-checking bench for upsample2d_nn. Two instances share one driver and
// monitor: a 2x2 instance for the main scenarios and a 3x1 instance for the
// narrow-frame case, selected by 'sel'. Expected outputs are pushed into a
// scoreboard queue when a frame is driven and popped as the DUT emits pixels.
// ----------------------------------------------------------------------------
module tb_upsample2d_nn;

    typedef struct packed {
        logic [7:0] data;
        logic       sol;
        logic       eol;
        logic       eof;
    } exp_t;

    typedef logic [7:0] pix_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       drv_valid;
    logic [7:0] drv_data;
    logic       drv_ready;

    logic       a_in_valid, a_in_ready, a_out_valid, a_sol, a_eol, a_eof;
    logic [7:0] a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_sol, b_eol, b_eof;
    logic [7:0] b_out_data;

    logic       mon_in_ready, mon_valid, mon_sol, mon_eol, mon_eof;
    logic [7:0] mon_data;

    exp_t       exp_q[$];
    exp_t       exp_e;
    int         total = 0;
    int         bad = 0;
    int         out_cnt = 0;
    int         rmode = 0;
    bit         mon_en = 1'b0;
    bit         abort = 1'b0;
    bit         feed_done = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic [2:0] stall_flags;
    logic       fire, fire_prev = 1'b0;
    pix_q_t     frame;

    always #5 clk = ~clk;

    assign a_in_valid = drv_valid && !sel;
    assign b_in_valid = drv_valid && sel;

    assign mon_in_ready = sel ? b_in_ready  : a_in_ready;
    assign mon_valid    = sel ? b_out_valid : a_out_valid;
    assign mon_data     = sel ? b_out_data  : a_out_data;
    assign mon_sol      = sel ? b_sol       : a_sol;
    assign mon_eol      = sel ? b_eol       : a_eol;
    assign mon_eof      = sel ? b_eof       : a_eof;

    upsample2d_nn #(.DATA_W(8), .IN_W(2), .IN_H(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (drv_data),
        .out_valid (a_out_valid),
        .out_ready (drv_ready),
        .out_data  (a_out_data),
        .out_sol   (a_sol),
        .out_eol   (a_eol),
        .out_eof   (a_eof)
    );

    upsample2d_nn #(.DATA_W(8), .IN_W(3), .IN_H(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (drv_data),
        .out_valid (b_out_valid),
        .out_ready (drv_ready),
        .out_data  (b_out_data),
        .out_sol   (b_sol),
        .out_eol   (b_eol),
        .out_eof   (b_eof)
    );

    // Single checking point: counts every comparison and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream ready pattern: always ready, alternating, or random stalls.
    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       drv_ready = ~drv_ready;
            2:       drv_ready = ($urandom_range(0, 3) != 0);
            default: drv_ready = 1'b1;
        endcase
    end

    // Monitor at the falling edge: a valid pixel with ready high transfers at
    // the next rising edge and is scored; a stalled pixel must look identical
    // on the next cycle. Accepts are also checked for never being adjacent.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_valid) begin
                if (stall_prev) begin
                    checkOutput("stall_data", 32'(mon_data), 32'(stall_data));
                    checkOutput("stall_flags", 32'({mon_sol, mon_eol, mon_eof}), 32'(stall_flags));
                end
                if (drv_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_out", 32'(exp_q.size()), 32'd1);
                    end else begin
                        exp_e = exp_q.pop_front();
                        checkOutput("out_data", 32'(mon_data), 32'(exp_e.data));
                        checkOutput("out_flags", 32'({mon_sol, mon_eol, mon_eof}),
                                    32'({exp_e.sol, exp_e.eol, exp_e.eof}));
                        out_cnt++;
                    end
                end
                stall_prev  = !drv_ready;
                stall_data  = mon_data;
                stall_flags = {mon_sol, mon_eol, mon_eof};
            end else begin
                stall_prev = 1'b0;
            end
            fire = drv_valid && mon_in_ready;
            if (fire) begin
                checkOutput("accept_spacing", 32'(fire_prev), 32'd0);
            end
            fire_prev = fire;
        end else begin
            stall_prev = 1'b0;
            fire_prev  = 1'b0;
        end
    end

    // Drive one frame into the selected DUT. The expected upsampled frame is
    // pushed to the scoreboard first; with gap set, three idle cycles follow
    // each accept and the output must go idle inside a ROW_A gap.
    task automatic applyStimulus(input pix_q_t px, input bit gap);
        int   w = sel ? 3 : 2;
        int   h = sel ? 1 : 2;
        int   tries;
        logic got;
        exp_t e;
        for (int r = 0; r < h; r++)
            for (int rep = 0; rep < 2; rep++)
                for (int c = 0; c < w; c++)
                    for (int ph = 0; ph < 2; ph++) begin
                        e.data = px[r * w + c];
                        e.sol  = (r == 0) && (rep == 0) && (c == 0) && (ph == 0);
                        e.eol  = (ph == 1) && (c == w - 1);
                        e.eof  = e.eol && (rep == 1) && (r == h - 1);
                        exp_q.push_back(e);
                    end
        for (int i = 0; i < px.size(); i++) begin
            drv_data  = px[i];
            drv_valid = 1'b1;
            tries     = 0;
            forever begin
                @(negedge clk);
                if (abort) break;
                got = mon_in_ready;
                @(posedge clk);
                #1;
                if (got) break;
                tries++;
                if (tries > 300) begin
                    checkOutput("accept_timeout", 32'(got), 32'd1);
                    break;
                end
            end
            if (abort) begin
                @(posedge clk);
                #1;
                break;
            end
            drv_valid = 1'b0;
            if (gap) begin
                if ((i % w) != (w - 1)) begin
                    @(negedge clk);
                    @(negedge clk);
                    @(negedge clk);
                    checkOutput("gap_idle", 32'(mon_valid), 32'd0);
                    @(posedge clk);
                    #1;
                end else begin
                    repeat (3) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
        drv_valid = 1'b0;
        feed_done = 1'b1;
    endtask

    // Wait, with a cycle budget, until every expected pixel has been seen.
    task automatic waitDrain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int start;
        rst       = 1'b1;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_data  = 8'd0;
        drv_ready = 1'b1;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid_a", 32'(a_out_valid), 32'd0);
        checkOutput("rst_data_a", 32'(a_out_data), 32'd0);
        checkOutput("rst_flags_a", 32'({a_sol, a_eol, a_eof}), 32'd0);
        checkOutput("rst_ready_a", 32'(a_in_ready), 32'd1);
        checkOutput("rst_valid_b", 32'(b_out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        $display("[TB] 2x2 frame, always ready");
        frame = '{8'd10, 8'd20, 8'd30, 8'd40};
        applyStimulus(frame, 1'b0);
        waitDrain();

        $display("[TB] 2x2 frame, alternating ready");
        rmode = 1;
        applyStimulus(frame, 1'b0);
        waitDrain();

        $display("[TB] 2x2 frame, random stalls");
        rmode = 2;
        applyStimulus(frame, 1'b0);
        waitDrain();
        rmode = 0;

        $display("[TB] 2x2 frame with input gaps");
        @(posedge clk);
        #1;
        applyStimulus(frame, 1'b1);
        waitDrain();

        $display("[TB] back-to-back frames");
        frame = '{8'd1, 8'd2, 8'd3, 8'd4};
        applyStimulus(frame, 1'b0);
        frame = '{8'd5, 8'd6, 8'd7, 8'd8};
        applyStimulus(frame, 1'b0);
        waitDrain();

        $display("[TB] reset mid-frame");
        start     = out_cnt;
        feed_done = 1'b0;
        frame     = '{8'd10, 8'd20, 8'd30, 8'd40};
        fork
            applyStimulus(frame, 1'b0);
        join_none
        for (int k = 0; k < 200 && out_cnt < start + 5; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_rst_outputs", 32'(out_cnt >= start + 5), 32'd1);
        abort = 1'b1;
        for (int k = 0; k < 50 && !feed_done; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort_done", 32'(feed_done), 32'd1);
        abort  = 1'b0;
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 32'(a_out_valid), 32'd0);
        checkOutput("midrst_flags", 32'({a_sol, a_eol, a_eof}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        frame  = '{8'd50, 8'd60, 8'd70, 8'd80};
        applyStimulus(frame, 1'b0);
        waitDrain();

        $display("[TB] 3x1 frame");
        sel   = 1'b1;
        frame = '{8'd1, 8'd2, 8'd3};
        applyStimulus(frame, 1'b0);
        waitDrain();

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #2000000;
        bad++;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
